// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified instruction/data memory: CPU datapath vs host/loader port.
// One access in flight; round-robin on ties, host_lock keeps the CPU out of arbitration.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_lat_cnt;
  logic [1:0]        w_lat_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic w_cpu_elig;
  logic w_host_elig;
  logic w_grant;
  logic w_winner;
  logic w_capture;

  assign w_cpu_elig  = cpu_req & ~host_lock;
  assign w_host_elig = host_req;
  // On a tie the requester that did not win last time goes next.
  assign w_winner    = (w_cpu_elig & w_host_elig) ? ~r_owner : w_host_elig;

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_elig | w_host_elig) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_state_nxt = S_RESP;
        end else begin
          w_lat_nxt   = LAT_LOAD;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Count reaches zero in cycle ACCESS+MEM_LAT, when read data is valid.
        if (r_lat_cnt != 2'd0) begin
          w_lat_nxt = r_lat_cnt - 2'd1;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_owner      <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      if (w_grant) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? host_we    : cpu_we;
        r_addr  <= w_winner ? host_addr  : cpu_addr;
        r_wdata <= w_winner ? host_wdata : cpu_wdata;
      end
      if (w_capture) begin
        if (r_owner) begin
          r_host_rdata <= mem_rdata;
        end else begin
          r_cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en     = (r_state == S_ACCESS);
  assign mem_we     = (r_state == S_ACCESS) & r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_done   = (r_state == S_RESP) & ~r_owner;
  assign host_done  = (r_state == S_RESP) &  r_owner;
  assign cpu_rdata  = r_cpu_rdata;
  assign host_rdata = r_host_rdata;
  assign owner      = r_owner;

endmodule
